cas_fsk_player: RTL and testbench



---
 rtl/cas_fsk_player.sv | 233 +++++++++++++++++++++++
 tb/tb_cas_fsk_player.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_fsk_player.sv
// Cassette playback engine: streams a CAS image from the byte store as a
// 1200/2400 Hz FSK square wave, with one-byte prefetch, motor pause and end-of-tape.
module cas_fsk_player #(
  parameter int ADDR_W = 16,
  parameter int CLK_HZ = 50_000_000,
  parameter int F1_HZ  = 2400,
  parameter int F0_HZ  = 1200,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              rewind,
  input  logic [ADDR_W:0]   tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              data,
  output logic              playing,
  output logic              eot,
  output logic [ADDR_W:0]   pos
);

  localparam int H1 = CLK_HZ / (2 * F1_HZ);
  localparam int H0 = CLK_HZ / (2 * F0_HZ);
  localparam int CW = $clog2(H0 + 1);
  localparam logic [CW-1:0] H1_M1 = CW'(H1 - 1);
  localparam logic [CW-1:0] H0_M1 = CW'(H0 - 1);
  localparam logic [2:0] LAT = 3'(RD_LAT);
  localparam logic [ADDR_W:0] POS_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_PLAY, ST_EOT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   pos_q, pos_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              data_q, data_d;
  logic              eot_q, eot_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic [CW-1:0]     half_q, half_d;
  logic [7:0]        nxt_buf_q, nxt_buf_d;
  logic              nxt_vld_q, nxt_vld_d;
  logic              rd_busy_q, rd_busy_d;
  logic [2:0]        rd_cnt_q, rd_cnt_d;
  logic              pf_req_q, pf_req_d;

  logic              cap_now;
  logic              nxt_avail;
  logic [7:0]        nxt_byte;
  logic [ADDR_W:0]   pos_inc;
  logic              more;

  function automatic logic [CW-1:0] half_len(input logic b);
    return b ? H1_M1 : H0_M1;
  endfunction

  assign cap_now   = rd_busy_q && (rd_cnt_q == LAT);
  assign nxt_avail = nxt_vld_q || cap_now;
  assign nxt_byte  = nxt_vld_q ? nxt_buf_q : mem_data;
  assign pos_inc   = pos_q + POS_ONE;
  assign more      = pos_inc < len_q;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    len_d     = len_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    data_d    = data_q;
    eot_d     = eot_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    half_d    = half_q;
    nxt_buf_d = nxt_buf_q;
    nxt_vld_d = nxt_vld_q;
    rd_busy_d = rd_busy_q;
    rd_cnt_d  = rd_cnt_q;
    pf_req_d  = pf_req_q;

    // An issued read always completes, even with the motor stopped.
    if (rd_busy_q) begin
      if (cap_now) begin
        rd_busy_d = 1'b0;
        nxt_buf_d = mem_data;
        nxt_vld_d = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + 3'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        data_d = 1'b0;
        pos_d  = '0;
        if (en) begin
          len_d = tape_len;
          if (tape_len == '0) begin
            state_d = ST_EOT;
            eot_d   = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (en) begin
          rd_d      = 1'b1;
          addr_d    = pos_q[ADDR_W-1:0];
          rd_busy_d = 1'b1;
          rd_cnt_d  = '0;
          nxt_vld_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (en && nxt_avail) begin
          shift_d   = nxt_byte;
          nxt_vld_d = 1'b0;
          bit_d     = '0;
          data_d    = 1'b1;
          half_d    = half_len(nxt_byte[0]);
          pf_req_d  = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (en) begin
          if (pf_req_q) begin
            pf_req_d = 1'b0;
            if (more) begin
              rd_d      = 1'b1;
              addr_d    = pos_inc[ADDR_W-1:0];
              rd_busy_d = 1'b1;
              rd_cnt_d  = '0;
            end
          end
          if (half_q != '0) begin
            half_d = half_q - CW'(1);
          end else if (data_q) begin
            data_d = 1'b0;
            half_d = half_len(shift_q[0]);
          end else if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            data_d  = 1'b1;
            half_d  = half_len(shift_q[1]);
          end else if (!more) begin
            state_d = ST_EOT;
            eot_d   = 1'b1;
            data_d  = 1'b0;
          end else begin
            // Byte boundary: the prefetched byte starts on the very next clock.
            pos_d    = pos_inc;
            bit_d    = '0;
            pf_req_d = 1'b1;
            if (nxt_avail) begin
              shift_d   = nxt_byte;
              nxt_vld_d = 1'b0;
              data_d    = 1'b1;
              half_d    = half_len(nxt_byte[0]);
            end else begin
              data_d  = 1'b0;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_EOT: begin
        data_d = 1'b0;
        eot_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rewind) begin
      state_d   = ST_IDLE;
      pos_d     = '0;
      data_d    = 1'b0;
      eot_d     = 1'b0;
      rd_d      = 1'b0;
      nxt_vld_d = 1'b0;
      rd_busy_d = 1'b0;
      pf_req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      data_q    <= 1'b0;
      eot_q     <= 1'b0;
      shift_q   <= '0;
      bit_q     <= '0;
      half_q    <= '0;
      nxt_buf_q <= '0;
      nxt_vld_q <= 1'b0;
      rd_busy_q <= 1'b0;
      rd_cnt_q  <= '0;
      pf_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      eot_q     <= eot_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      half_q    <= half_d;
      nxt_buf_q <= nxt_buf_d;
      nxt_vld_q <= nxt_vld_d;
      rd_busy_q <= rd_busy_d;
      rd_cnt_q  <= rd_cnt_d;
      pf_req_q  <= pf_req_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign data     = data_q;
  assign eot      = eot_q;
  assign pos      = pos_q;
  assign playing  = (state_q == ST_PLAY) && en;

endmodule

// File: tb/tb_cas_fsk_player.sv
// Bench for cas_fsk_player: a latency-2 byte store plus a segment scoreboard of
// expected FSK half-periods compared against the measured data waveform.
module tb_cas_fsk_player;

  localparam int ADDR_W = 8;
  localparam int CLK_HZ = 48000;
  localparam int F1_HZ  = 2400;
  localparam int F0_HZ  = 1200;
  localparam int RD_LAT = 2;
  localparam int H1 = CLK_HZ / (2 * F1_HZ);
  localparam int H0 = CLK_HZ / (2 * F0_HZ);

  typedef struct packed {
    logic lvl;
    int   len;
    int   pos;
  } seg_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              rewind;
  logic [ADDR_W:0]   tape_len;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              data;
  logic              playing;
  logic              eot;
  logic [ADDR_W:0]   pos;

  logic [7:0] mem [0:255];
  logic [7:0] pipe1 = 8'hC3;
  logic [7:0] pipe2 = 8'hC3;

  seg_t       exp_seg[$];
  seg_t       obs_seg[$];
  logic [7:0] obs_addr[$];
  logic       prev_rd = 1'b0;
  int         rd_consec = 0;

  int n_checks = 0;
  int n_fails  = 0;
  int timed_out, eot_k, first_k, play_bad;

  cas_fsk_player #(
    .ADDR_W(ADDR_W), .CLK_HZ(CLK_HZ), .F1_HZ(F1_HZ), .F0_HZ(F0_HZ), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .rewind(rewind), .tape_len(tape_len),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .data(data), .playing(playing), .eot(eot), .pos(pos)
  );

  always #5 clk = ~clk;

  // Byte store: data appears RD_LAT cycles after the strobe; filler otherwise.
  always @(posedge clk) begin
    pipe1 <= mem_rd ? mem[mem_addr] : 8'hC3;
    pipe2 <= pipe1;
  end
  assign mem_data = pipe2;

  always @(posedge clk) begin
    #1;
    if (mem_rd) begin
      obs_addr.push_back(mem_addr);
      if (prev_rd) rd_consec++;
    end
    prev_rd = mem_rd;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_expected(input int first, input int nbytes);
    seg_t s;
    for (int b = first; b < first + nbytes; b++) begin
      for (int i = 0; i < 8; i++) begin
        s.lvl = 1'b1; s.len = mem[b][i] ? H1 : H0; s.pos = b;
        exp_seg.push_back(s);
        s.lvl = 1'b0;
        exp_seg.push_back(s);
      end
    end
  endtask

  // Records high/low runs of data from the next negedge until nseg runs, eot or timeout.
  task automatic capture(input int nseg, input int max_cyc);
    int k, run, spos;
    logic cur, started;
    seg_t s;
    obs_seg.delete();
    timed_out = 0; eot_k = -1; first_k = -1; play_bad = 0;
    k = 0; run = 0; spos = 0; cur = 1'b0; started = 1'b0;
    forever begin
      @(negedge clk);
      k++;
      if (k > max_cyc) begin timed_out = 1; break; end
      if (eot) begin
        if (started) begin
          s.lvl = cur; s.len = run; s.pos = spos;
          obs_seg.push_back(s);
        end
        eot_k = k;
        break;
      end
      if (!started) begin
        if (data === 1'b1) begin
          started = 1'b1; cur = 1'b1; run = 1; first_k = k; spos = int'(pos);
        end
      end else if (data === cur) begin
        run++;
      end else begin
        s.lvl = cur; s.len = run; s.pos = spos;
        obs_seg.push_back(s);
        if (obs_seg.size() >= nseg) break;
        cur = data; run = 1; spos = int'(pos);
      end
      if (started && playing !== 1'b1) play_bad++;
    end
  endtask

  task automatic do_rewind();
    @(negedge clk);
    en = 1'b0;
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; rewind = 1'b0; tape_len = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (data !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_data: got %b expected 0", data); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    n_checks++; if (mem_addr !== '0) begin n_fails++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
    n_checks++; if (playing !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_playing: got %b expected 0", playing); end
    n_checks++; if (eot !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_eot: got %b expected 0", eot); end
    n_checks++; if (pos !== '0) begin n_fails++; $display("[TB] FAIL reset_pos: got %0d expected 0", pos); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    seg_t e, o;
    int idx;
    mem[0] = 8'h55;
    tape_len = 9'd1;
    obs_addr.delete(); exp_seg.delete();
    push_expected(0, 1);
    en = 1'b1;
    capture(1000, 400);
    n_checks++; if (timed_out != 0) begin n_fails++; $display("[TB] FAIL single_timeout: got timeout expected eot"); end
    n_checks++; if (first_k != 5) begin n_fails++; $display("[TB] FAIL single_latency: got %0d expected 5", first_k); end
    n_checks++; if (eot_k != 245) begin n_fails++; $display("[TB] FAIL single_eot_cycle: got %0d expected 245", eot_k); end
    n_checks++; if (playing !== 1'b0) begin n_fails++; $display("[TB] FAIL single_playing_eot: got %b expected 0", playing); end
    n_checks++; if (play_bad != 0) begin n_fails++; $display("[TB] FAIL single_playing: got %0d low samples expected 0", play_bad); end
    idx = 0;
    while (exp_seg.size() > 0) begin
      e = exp_seg.pop_front();
      n_checks++;
      if (obs_seg.size() == 0) begin
        n_fails++; $display("[TB] FAIL single_seg%0d: got none expected lvl=%0d len=%0d", idx, e.lvl, e.len);
      end else begin
        o = obs_seg.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL single_seg%0d: got lvl=%0d len=%0d pos=%0d expected lvl=%0d len=%0d pos=%0d",
                   idx, o.lvl, o.len, o.pos, e.lvl, e.len, e.pos);
        end
      end
      idx++;
    end
    n_checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 8'd0) begin
      n_fails++; $display("[TB] FAIL single_reads: got %0d reads expected 1 at addr 0", obs_addr.size());
    end
    do_rewind();
    n_checks++; if (eot !== 1'b0 || pos !== '0) begin n_fails++; $display("[TB] FAIL rewind_from_eot: got eot=%b pos=%0d expected 0/0", eot, pos); end
  endtask

  task automatic test_back_to_back();
    seg_t e, o;
    int idx;
    mem[0] = 8'hFF; mem[1] = 8'h00;
    tape_len = 9'd2;
    obs_addr.delete(); exp_seg.delete();
    rd_consec = 0;
    push_expected(0, 2);
    en = 1'b1;
    capture(1000, 700);
    n_checks++; if (eot_k != 5 + 8 * 2 * H1 + 8 * 2 * H0) begin n_fails++; $display("[TB] FAIL b2b_eot_cycle: got %0d expected %0d", eot_k, 5 + 16 * H1 + 16 * H0); end
    idx = 0;
    while (exp_seg.size() > 0) begin
      e = exp_seg.pop_front();
      n_checks++;
      if (obs_seg.size() == 0) begin
        n_fails++; $display("[TB] FAIL b2b_seg%0d: got none expected lvl=%0d len=%0d", idx, e.lvl, e.len);
      end else begin
        o = obs_seg.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL b2b_seg%0d: got lvl=%0d len=%0d pos=%0d expected lvl=%0d len=%0d pos=%0d",
                   idx, o.lvl, o.len, o.pos, e.lvl, e.len, e.pos);
        end
      end
      idx++;
    end
    n_checks++;
    if (obs_addr.size() != 2) begin
      n_fails++; $display("[TB] FAIL b2b_read_count: got %0d expected 2", obs_addr.size());
    end else if (obs_addr[0] !== 8'd0 || obs_addr[1] !== 8'd1) begin
      n_fails++; $display("[TB] FAIL b2b_read_addr: got %0d,%0d expected 0,1", obs_addr[0], obs_addr[1]);
    end
    n_checks++; if (rd_consec != 0) begin n_fails++; $display("[TB] FAIL b2b_rd_consecutive: got %0d expected 0", rd_consec); end
    do_rewind();
  endtask

  task automatic test_pause();
    seg_t e;
    int t, bad, cnt;
    mem[0] = 8'h00;
    tape_len = 9'd1;
    exp_seg.delete();
    en = 1'b1;
    t = 0;
    while (data !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (t != 5) begin n_fails++; $display("[TB] FAIL pause_latency: got %0d expected 5", t); end
    repeat (6) @(negedge clk);
    en = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (data !== 1'b1 || playing !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fails++; $display("[TB] FAIL pause_frozen: got %0d bad cycles expected 0", bad); end
    en = 1'b1;
    e.lvl = 1'b1; e.len = H0 - 7; e.pos = 0; exp_seg.push_back(e);
    e.lvl = 1'b0; e.len = H0;                 exp_seg.push_back(e);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (data !== 1'b1 || cnt >= 100) break;
      cnt++;
    end
    e = exp_seg.pop_front();
    n_checks++; if (cnt != e.len) begin n_fails++; $display("[TB] FAIL pause_resume_high: got %0d expected %0d", cnt, e.len); end
    cnt = 1;
    forever begin
      @(negedge clk);
      if (data !== 1'b0 || eot === 1'b1 || cnt >= 100) break;
      cnt++;
    end
    e = exp_seg.pop_front();
    n_checks++; if (cnt != e.len) begin n_fails++; $display("[TB] FAIL pause_low: got %0d expected %0d", cnt, e.len); end
    do_rewind();
  endtask

  task automatic test_rewind();
    seg_t e, o;
    int t, idx;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;
    tape_len = 9'd6;
    exp_seg.delete();
    en = 1'b1;
    t = 0;
    while (pos !== 9'd3 && t < 2000) begin @(negedge clk); t++; end
    n_checks++; if (pos !== 9'd3) begin n_fails++; $display("[TB] FAIL rewind_reach_byte3: got pos=%0d expected 3", pos); end
    repeat (30) @(negedge clk);
    rewind = 1'b1;
    @(negedge clk);
    n_checks++; if (pos !== '0) begin n_fails++; $display("[TB] FAIL rewind_pos: got %0d expected 0", pos); end
    n_checks++; if (data !== 1'b0) begin n_fails++; $display("[TB] FAIL rewind_data: got %b expected 0", data); end
    n_checks++; if (playing !== 1'b0 || eot !== 1'b0) begin n_fails++; $display("[TB] FAIL rewind_status: got playing=%b eot=%b expected 0/0", playing, eot); end
    rewind = 1'b0;
    obs_addr.delete();
    push_expected(0, 1);
    capture(16, 600);
    n_checks++; if (first_k != 5) begin n_fails++; $display("[TB] FAIL rewind_restart_latency: got %0d expected 5", first_k); end
    n_checks++;
    if (obs_addr.size() == 0 || obs_addr[0] !== 8'd0) begin
      n_fails++; $display("[TB] FAIL rewind_restart_addr: got %0d reads expected first read at 0", obs_addr.size());
    end
    idx = 0;
    while (exp_seg.size() > 0) begin
      e = exp_seg.pop_front();
      n_checks++;
      if (obs_seg.size() == 0) begin
        n_fails++; $display("[TB] FAIL rewind_seg%0d: got none expected lvl=%0d len=%0d", idx, e.lvl, e.len);
      end else begin
        o = obs_seg.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL rewind_seg%0d: got lvl=%0d len=%0d pos=%0d expected lvl=%0d len=%0d pos=%0d",
                   idx, o.lvl, o.len, o.pos, e.lvl, e.len, e.pos);
        end
      end
      idx++;
    end
    do_rewind();
  endtask

  task automatic test_zero_len();
    tape_len = '0;
    obs_addr.delete();
    en = 1'b1;
    capture(1, 20);
    n_checks++; if (eot_k < 1 || eot_k > 2) begin n_fails++; $display("[TB] FAIL zero_eot_cycle: got %0d expected 1..2", eot_k); end
    n_checks++; if (obs_seg.size() != 0) begin n_fails++; $display("[TB] FAIL zero_data: got %0d high runs expected 0", obs_seg.size()); end
    repeat (5) @(negedge clk);
    n_checks++; if (obs_addr.size() != 0) begin n_fails++; $display("[TB] FAIL zero_reads: got %0d expected 0", obs_addr.size()); end
    n_checks++; if (eot !== 1'b1 || data !== 1'b0) begin n_fails++; $display("[TB] FAIL zero_hold: got eot=%b data=%b expected 1/0", eot, data); end
    do_rewind();
  endtask

  task automatic test_reset_in_flight();
    seg_t e, o;
    int t, idx;
    mem[0] = 8'h0F; mem[1] = 8'hF0;
    tape_len = 9'd2;
    obs_addr.delete(); exp_seg.delete();
    en = 1'b1;
    t = 0;
    while (obs_addr.size() < 2 && t < 200) begin @(negedge clk); t++; end
    n_checks++; if (obs_addr.size() != 2) begin n_fails++; $display("[TB] FAIL rif_prefetch: got %0d reads expected 2", obs_addr.size()); end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== '0 || playing !== 1'b0 || eot !== 1'b0 || pos !== '0) begin
      n_fails++;
      $display("[TB] FAIL rif_reset_outputs: got data=%b rd=%b addr=%0d playing=%b eot=%b pos=%0d expected all 0",
               data, mem_rd, mem_addr, playing, eot, pos);
    end
    en = 1'b0;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (data !== 1'b0 || pos !== '0 || obs_addr.size() != 2) begin n_fails++; $display("[TB] FAIL rif_idle_after: got data=%b pos=%0d reads=%0d expected 0/0/2", data, pos, obs_addr.size()); end
    push_expected(0, 1);
    en = 1'b1;
    capture(16, 600);
    n_checks++; if (first_k != 5) begin n_fails++; $display("[TB] FAIL rif_restart_latency: got %0d expected 5", first_k); end
    idx = 0;
    while (exp_seg.size() > 0) begin
      e = exp_seg.pop_front();
      n_checks++;
      if (obs_seg.size() == 0) begin
        n_fails++; $display("[TB] FAIL rif_seg%0d: got none expected lvl=%0d len=%0d", idx, e.lvl, e.len);
      end else begin
        o = obs_seg.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL rif_seg%0d: got lvl=%0d len=%0d pos=%0d expected lvl=%0d len=%0d pos=%0d",
                   idx, o.lvl, o.len, o.pos, e.lvl, e.len, e.pos);
        end
      end
      idx++;
    end
    do_rewind();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_pause();
    test_rewind();
    test_zero_len();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
